uo_trace_capture: RTL and testbench
===================================

UO_TRACE_CAPTURE -- requirements
Module: uo_trace_capture

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; power of two, 4..16.
REQ-002 Parameter DATA_W, default 8, width of the traced bus.
REQ-003 Parameter TS_W, default 8, width of the delta timestamp.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 trace_in  input  DATA_W  user-project output bus (uo_out), sampled every clk.
REQ-007 arm  input  1  pulse; starts a capture session.
REQ-008 stop  input  1  pulse; ends the capture session.
REQ-009 ev_data  output  DATA_W  FIFO head data.
REQ-010 ev_delta  output  TS_W  FIFO head timestamp delta.
REQ-011 ev_valid  output  1  FIFO head is valid.
REQ-012 ev_ready  input  1  consumer accepts the head.
REQ-013 busy  output  1  high in ARMED or CAPTURE.
REQ-014 overflow  output  1  sticky; at least one event was dropped.
REQ-015 count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 The FSM SHALL have the states IDLE, ARMED and CAPTURE.
REQ-017 IDLE->ARMED on arm; ARMED->CAPTURE next cycle; CAPTURE->IDLE on stop; stop in ARMED->IDLE.
REQ-018 arm outside IDLE SHALL be ignored; arm and stop in the same cycle SHALL resolve to stop.
REQ-019 On entering ARMED: prev register <= trace_in, delta counter <= 0, overflow cleared; FIFO contents kept.
REQ-020 First CAPTURE cycle: one "initial" event {data=trace_in, delta=0} SHALL be pushed unconditionally.
REQ-021 Later CAPTURE cycles: delta counter increments by 1 each cycle; when trace_in != prev, push {trace_in, delta+1}, update prev, reset delta to 0.
REQ-022 Saturation: if delta+1 == 2^TS_W-1 with no change, push {prev, 2^TS_W-1} and reset delta to 0 (keep-alive event).
REQ-023 Time reconstruction SHALL be exact: sum of deltas = cycles since first event.
REQ-024 Push latency: an event is visible on ev_valid in the cycle after the sampled edge (1-cycle latency).
REQ-025 Pop SHALL occur when ev_valid && ev_ready; ev_data and ev_delta stay stable while ev_valid && !ev_ready.
REQ-026 FIFO full on push: the event is dropped, overflow <= 1, delta still resets (the next delta counts from the dropped event).
REQ-027 Push and pop in the same cycle while full SHALL both succeed (count unchanged, no overflow).
REQ-028 Push and pop in the same cycle while empty: the new entry appears next cycle; no bypass.
REQ-029 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH exactly.
REQ-030 The FIFO SHALL keep draining in IDLE.
REQ-031 A change on the cycle stop is asserted SHALL still be captured.

Reset
REQ-032 rst SHALL force: state IDLE, FIFO empty (pointers 0, count 0), ev_valid 0, overflow 0, busy 0, prev 0, delta 0.
REQ-033 rst mid-capture SHALL discard all queued events; ev_data/ev_delta are don't-care while ev_valid=0.
REQ-034 rst SHALL take priority over arm, stop and ev_ready.

Structure
REQ-035 Package uo_trace_pkg SHALL hold the state enum and the TS_MAX constant.
REQ-036 Storage SHALL be one sub-module, trace_fifo (sync FIFO, width DATA_W+TS_W, DEPTH, full/empty/count); FSM and timestamp logic live at top.

Verification
REQ-037 Reset, arm, trace_in=0x00 constant 300 cycles, ev_ready=1 -> events {00,0},{00,255},{00,45 partial not emitted}; exactly 2 events, busy=1.
REQ-038 Arm; trace_in 0x00->0x5A at capture cycle 3, ->0xA5 at cycle 7 -> events {00,0},{5A,3},{A5,4}.
REQ-039 ev_ready=0, DEPTH=8, 10 changes -> count=8, overflow=1; the first 8 events drain intact once ready rises.
REQ-040 FIFO full, ev_ready=1 and a change in the same cycle -> count stays 8, overflow stays 0.
REQ-041 rst asserted with count=5 mid-capture -> next cycle: count=0, ev_valid=0, busy=0, overflow=0.
REQ-042 arm+stop together in IDLE -> stays IDLE, no event; change coincident with stop -> captured, then busy=0.

Source files
------------

// File: rtl/uo_trace_capture_pkg.sv
// Shared state encoding and timestamp constants for the uo_out trace capture block.
package uo_trace_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2
   } trace_state_e;

   localparam int TS_W_DEFAULT = 8;

   // Largest representable delta; reaching it forces a keep-alive event.
   function automatic int ts_max(input int w);
      return (1 << w) - 1;
   endfunction

   localparam int TS_MAX = ts_max(TS_W_DEFAULT);

endpackage

// File: rtl/uo_trace_capture_fifo.sv
// Synchronous FIFO holding {data, delta} trace events; read port is the combinational head.
module trace_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign do_rd   = rd_en && !empty;
   // A write into a full FIFO is only accepted when the head leaves in the same cycle.
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uo_trace_capture.sv
// Change-triggered trace capture of the user-project output bus with delta timestamps.
module uo_trace_capture
   import uo_trace_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8,
   parameter int TS_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        trace_in,
   input  logic                     arm,
   input  logic                     stop,
   output logic [DATA_W-1:0]        ev_data,
   output logic [TS_W-1:0]          ev_delta,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic                     busy,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
);

   localparam logic [TS_W-1:0] DELTA_MAX = TS_W'(ts_max(TS_W));
   localparam logic [TS_W-1:0] DELTA_ONE = TS_W'(1);

   trace_state_e             state_q;
   trace_state_e             state_d;
   logic [DATA_W-1:0]        prev_q;
   logic [DATA_W-1:0]        prev_d;
   logic [TS_W-1:0]          delta_q;
   logic [TS_W-1:0]          delta_d;
   logic [TS_W-1:0]          delta_inc;
   logic [DATA_W-1:0]        push_data;
   logic [TS_W-1:0]          push_delta;
   logic                     push;
   logic                     pop;
   logic                     first_q;
   logic                     overflow_q;
   logic                     enter_armed;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [DATA_W+TS_W-1:0]   head;

   // Stop outranks arm, so a simultaneous arm+stop in IDLE leaves the block idle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arm && !stop) state_d = ARMED;
         ARMED:   state_d = stop ? IDLE : CAPTURE;
         CAPTURE: if (stop) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign enter_armed = (state_q == IDLE) && (state_d == ARMED);

   // Event generation still runs on the stop cycle so a coincident change is not lost.
   always_comb begin
      push       = 1'b0;
      push_data  = trace_in;
      push_delta = '0;
      prev_d     = prev_q;
      delta_d    = delta_q;
      delta_inc  = delta_q + DELTA_ONE;
      if (enter_armed) begin
         prev_d  = trace_in;
         delta_d = '0;
      end else if (state_q == CAPTURE) begin
         if (first_q) begin
            push    = 1'b1;
            prev_d  = trace_in;
            delta_d = '0;
         end else if (trace_in != prev_q) begin
            push       = 1'b1;
            push_delta = delta_inc;
            prev_d     = trace_in;
            delta_d    = '0;
         end else if (delta_inc == DELTA_MAX) begin
            push       = 1'b1;
            push_data  = prev_q;
            push_delta = DELTA_MAX;
            delta_d    = '0;
         end else begin
            delta_d = delta_inc;
         end
      end
   end

   // Delta restarts even when the FIFO drops the event, keeping later timestamps exact.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         prev_q     <= '0;
         delta_q    <= '0;
         first_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         delta_q <= delta_d;
         first_q <= (state_q == ARMED) && (state_d == CAPTURE);
         if (enter_armed)
            overflow_q <= 1'b0;
         else if (push && fifo_full && !pop)
            overflow_q <= 1'b1;
      end
   end

   assign ev_valid = !fifo_empty;
   assign pop      = ev_valid && ev_ready;

   trace_fifo #(
      .WIDTH (DATA_W + TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data ({push_data, push_delta}),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (count)
   );

   assign ev_data  = head[DATA_W+TS_W-1:TS_W];
   assign ev_delta = head[TS_W-1:0];
   assign busy     = (state_q != IDLE);
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uo_trace_capture.sv
// Scoreboard bench for uo_trace_capture: directed sessions push expected events, a monitor pops them.
module tb_uo_trace_capture;
   import uo_trace_pkg::*;

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] delta;
   } ev_t;

   logic       clk;
   logic       rst;
   logic [7:0] trace_in;
   logic       arm;
   logic       stop;
   logic [7:0] ev_data;
   logic [7:0] ev_delta;
   logic       ev_valid;
   logic       ev_ready;
   logic       busy;
   logic       overflow;
   logic [3:0] count;

   ev_t exp_q[$];
   ev_t mon_e;
   int  total;
   int  bad;

   uo_trace_capture #(
      .DEPTH  (8),
      .DATA_W (8),
      .TS_W   (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .trace_in (trace_in),
      .arm      (arm),
      .stop     (stop),
      .ev_data  (ev_data),
      .ev_delta (ev_delta),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .busy     (busy),
      .overflow (overflow),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] t, input logic a, input logic s);
      trace_in = t;
      arm      = a;
      stop     = s;
      tick();
      arm      = 1'b0;
      stop     = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s got=%0h want=%0h", name, actual, expected);
      end
   endtask

   task automatic expect_ev(input logic [7:0] d, input logic [7:0] t);
      exp_q.push_back('{data: d, delta: t});
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      tick();
      checkOutput(name, exp_q.size(), 0);
   endtask

   // Handshake is judged on the falling edge; the pop itself happens at the next rising edge.
   always @(negedge clk) begin
      if (!rst && ev_valid && ev_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_event got data=%h delta=%0d want none", ev_data, ev_delta);
         end else begin
            mon_e = exp_q.pop_front();
            if (ev_data !== mon_e.data || ev_delta !== mon_e.delta) begin
               bad++;
               $display("[TB] FAIL event got data=%h delta=%0d want data=%h delta=%0d",
                        ev_data, ev_delta, mon_e.data, mon_e.delta);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      trace_in = 8'h00;
      arm      = 1'b0;
      stop     = 1'b0;
      ev_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      checkOutput("reset_valid", ev_valid, 0);
      checkOutput("reset_count", count, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_overflow", overflow, 0);

      // Constant bus for 300 cycles: initial event plus one keep-alive only.
      ev_ready = 1'b1;
      applyStimulus(8'h00, 1'b1, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0);
      expect_ev(8'h00, 8'h00);
      expect_ev(8'h00, 8'(TS_MAX));
      for (int k = 0; k < 300; k++) applyStimulus(8'h00, 1'b0, 1'b0);
      checkOutput("t1_busy", busy, 1);
      checkOutput("t1_count", count, 0);
      checkOutput("t1_events_left", exp_q.size(), 0);
      applyStimulus(8'h00, 1'b0, 1'b1);
      checkOutput("t1_stop_busy", busy, 0);

      // Changes at capture cycles 3, 7 and a change coincident with stop at 10.
      applyStimulus(8'h00, 1'b1, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0);
      expect_ev(8'h00, 8'd0);
      applyStimulus(8'h00, 1'b0, 1'b0);
      checkOutput("t2_latency_valid", ev_valid, 1);
      expect_ev(8'h5A, 8'd3);
      expect_ev(8'hA5, 8'd4);
      for (int k = 1; k < 10; k++)
         applyStimulus((k < 3) ? 8'h00 : (k < 7) ? 8'h5A : 8'hA5, 1'b0, 1'b0);
      expect_ev(8'h3C, 8'd3);
      applyStimulus(8'h3C, 1'b0, 1'b1);
      checkOutput("t2_stop_busy", busy, 0);
      wait_drain("t2_drain");
      checkOutput("t2_count", count, 0);

      // Arm and stop together in IDLE resolve to stop.
      applyStimulus(8'h3C, 1'b1, 1'b1);
      applyStimulus(8'h3C, 1'b0, 1'b0);
      checkOutput("t3_busy", busy, 0);
      checkOutput("t3_valid", ev_valid, 0);

      // Fill the FIFO with the consumer stalled, then full push+pop, then drops.
      ev_ready = 1'b0;
      applyStimulus(8'h3C, 1'b1, 1'b0);
      applyStimulus(8'h3C, 1'b0, 1'b0);
      expect_ev(8'h3C, 8'd0);
      applyStimulus(8'h3C, 1'b0, 1'b0);
      for (int k = 1; k < 8; k++) begin
         expect_ev(8'h10 + 8'(k), 8'd1);
         applyStimulus(8'h10 + 8'(k), 1'b0, 1'b0);
      end
      checkOutput("t4_full_count", count, 8);
      checkOutput("t4_full_overflow", overflow, 0);
      ev_ready = 1'b1;
      expect_ev(8'h18, 8'd1);
      applyStimulus(8'h18, 1'b0, 1'b0);
      ev_ready = 1'b0;
      checkOutput("t4_pushpop_count", count, 8);
      checkOutput("t4_pushpop_overflow", overflow, 0);
      applyStimulus(8'h19, 1'b0, 1'b0);
      applyStimulus(8'h1A, 1'b0, 1'b0);
      checkOutput("t4_drop_count", count, 8);
      checkOutput("t4_drop_overflow", overflow, 1);
      applyStimulus(8'h1A, 1'b0, 1'b0);
      applyStimulus(8'h1A, 1'b0, 1'b0);
      ev_ready = 1'b1;
      expect_ev(8'h1B, 8'd3);
      applyStimulus(8'h1B, 1'b0, 1'b1);
      checkOutput("t4_stop_busy", busy, 0);
      wait_drain("t4_drain");
      checkOutput("t4_sticky_overflow", overflow, 1);
      checkOutput("t4_count", count, 0);

      // Reset mid-capture with five queued events; reset outranks arm and ev_ready.
      ev_ready = 1'b0;
      applyStimulus(8'h1B, 1'b1, 1'b0);
      applyStimulus(8'h1B, 1'b0, 1'b0);
      applyStimulus(8'h1B, 1'b0, 1'b0);
      for (int k = 1; k < 5; k++) applyStimulus(8'h20 + 8'(k), 1'b0, 1'b0);
      checkOutput("t5_pre_count", count, 5);
      checkOutput("t5_pre_busy", busy, 1);
      rst      = 1'b1;
      arm      = 1'b1;
      ev_ready = 1'b1;
      tick();
      checkOutput("t5_rst_count", count, 0);
      checkOutput("t5_rst_valid", ev_valid, 0);
      checkOutput("t5_rst_busy", busy, 0);
      checkOutput("t5_rst_overflow", overflow, 0);
      rst      = 1'b0;
      arm      = 1'b0;
      ev_ready = 1'b0;
      tick();
      checkOutput("t5_post_busy", busy, 0);
      checkOutput("final_queue", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
